icache_fill: RTL
================

Name: icache_fill

Overview:
- Direct-mapped, read-only instruction cache between the instruction-fetch stage and the memory controller's instruction-fetch port.
- Hits return a 32-bit instruction in the same cycle.
- Misses issue one line-aligned line-fetch request, wait for the memory controller's done pulse, write the line, then serve the access.

Parameters:
LINE_BYTES, 16, bytes per line; must equal the memory controller's IF line length.
NUM_LINES, 16, number of lines; power of two.
ADDR_W, 32, address width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset; rst=0 resets immediately.
rdy  input  1  global ready; 0 freezes all state.
flush  input  1  invalidate all lines (fence.i / rollback).
fetch_en  input  1  fetch request valid.
fetch_pc  input  ADDR_W  fetch address; bits [1:0] always 0.
fetch_hit  output  1  fetch_inst valid this cycle (combinational).
fetch_inst  output  32  instruction word at fetch_pc.
mem_if_en  output  1  line-fetch request to the memory controller (registered).
mem_if_pc  output  ADDR_W  line-aligned fetch address (registered).
mem_if_done  input  1  one-cycle pulse: mem_if_data valid.
mem_if_data  input  LINE_BYTES*8  fetched line; byte i at bits [8i+7:8i].

Behaviour:
- Address split:
  - OFF = log2(LINE_BYTES); IDX = log2(NUM_LINES).
  - offset = pc[OFF-1:0]; index = pc[OFF+IDX-1:OFF]; tag = pc[ADDR_W-1:OFF+IDX].
- Storage: per line, one valid bit, one tag, and LINE_BYTES bytes of data.
- Hit condition: fetch_hit = fetch_en & valid[index] & tag match & state==IDLE & !flush.
  - fetch_inst = little-endian word at offset (bytes offset..offset+3); 0 when not hit.
- Reset (rst=0):
  - state=IDLE; all valid=0; mem_if_en=0; mem_if_pc=0; drop=0.
  - fetch_hit=0, fetch_inst=0.
  - Reset during WAIT abandons the request. The memory controller is reset on the same reset, so no stray done is expected.
- rdy=0: no state, valid, tag, data, or output-register change.
  - fetch_hit is still computed combinationally, but the fetch stage must ignore it.
- State machine: IDLE, WAIT.
  - IDLE: if fetch_en & !hit & !flush:
    - mem_if_en<=1; mem_if_pc<={fetch_pc[ADDR_W-1:OFF], OFF'b0}.
    - Latch the miss index and tag; go to WAIT.
  - WAIT: hold mem_if_en=1 and mem_if_pc until mem_if_done=1. Then:
    - mem_if_en<=0.
    - If !drop: write the line data, tag, and valid=1 at the latched index.
    - drop<=0; go to IDLE.
  - Miss-to-hit latency: the request is registered at edge 0, and the line is written on the edge where done is sampled. The next cycle is a hit if fetch_pc is unchanged.
- Request handshake: mem_if_en drops on the same edge mem_if_done is sampled, so the memory controller never sees a stale request in its following IDLE.
  - The memory controller may delay the request (it gives priority to load/store); the cache waits indefinitely.
- Flush:
  - In IDLE: all valid<=0 on that edge; no request issued that cycle.
  - In WAIT: all valid<=0, drop<=1. The outstanding fetch completes normally but its data is discarded, so stale instructions are never installed.
  - Flush coincident with mem_if_done: discard the data; valid stays all 0.
- Change of fetch_pc while in WAIT: ignored. The fetch stage retries after return to IDLE (a miss again if the index differs).
- Same index with a different tag: the fill overwrites the line (no associativity).
- fetch_en=0 in IDLE: no request; outputs idle.

Test Plan:
1. Cold miss: reset, fetch_en=1, fetch_pc=0x0000_1004.
   - Expect mem_if_en=1, mem_if_pc=0x0000_1000.
   - Pulse done with line bytes 0x00..0x0F → next cycle fetch_hit=1, fetch_inst=0x0706_0504.
2. Hit in the same line: after test 1, fetch_pc=0x0000_100C → same-cycle fetch_hit=1, fetch_inst=0x0F0E_0D0C, mem_if_en stays 0.
3. Conflict eviction: fetch_pc=0x0000_1104 (same index, new tag) → miss, mem_if_pc=0x0000_1100.
   - After fill, 0x0000_1004 misses again.
4. Flush during WAIT: miss on 0x2000, assert flush 3 cycles before done.
   - After done: state IDLE, fetch_hit=0 for 0x2000, and a new request for 0x2000 is issued.
5. Delayed done with rdy toggling: hold done off 20 cycles with rdy=0 for cycles 5–8.
   - mem_if_en and mem_if_pc stay stable throughout; fill succeeds after done.
6. Async reset mid-WAIT: drive rst=0 between clock edges → mem_if_en=0 immediately, all lines invalid, and 0x0000_1004 misses after release.

Source files
------------

// File: rtl/icache_fill.sv
// Direct-mapped, read-only instruction cache with a single outstanding
// line fill toward the memory controller's instruction-fetch port.
// Hits are answered combinationally. A miss raises a registered
// line-aligned request that is held until the controller pulses done.
module icache_fill #(
   parameter int LINE_BYTES = 16,
   parameter int NUM_LINES  = 16,
   parameter int ADDR_W     = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    flush,
   input  logic                    fetch_en,
   input  logic [ADDR_W-1:0]       fetch_pc,
   output logic                    fetch_hit,
   output logic [31:0]             fetch_inst,
   output logic                    mem_if_en,
   output logic [ADDR_W-1:0]       mem_if_pc,
   input  logic                    mem_if_done,
   input  logic [LINE_BYTES*8-1:0] mem_if_data
);

   localparam int OFF   = $clog2(LINE_BYTES);
   localparam int IDX   = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - OFF - IDX;

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [7:0]           data_mem [NUM_LINES][LINE_BYTES];

   logic                 mem_if_en_d;
   logic [ADDR_W-1:0]    mem_if_pc_d;
   logic                 drop_q, drop_d;
   logic [IDX-1:0]       miss_idx_q, miss_idx_d;
   logic [TAG_W-1:0]     miss_tag_q, miss_tag_d;
   logic                 fill_we;
   logic                 clear_all;

   logic [OFF-1:0]       pc_off;
   logic [IDX-1:0]       pc_idx;
   logic [TAG_W-1:0]     pc_tag;
   logic                 lookup_hit;

   assign pc_off     = fetch_pc[OFF-1:0];
   assign pc_idx     = fetch_pc[OFF+IDX-1:OFF];
   assign pc_tag     = fetch_pc[ADDR_W-1:OFF+IDX];
   assign lookup_hit = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

   // A hit is only reported while no fill is outstanding and no flush is
   // invalidating the array in this cycle.
   assign fetch_hit = fetch_en && lookup_hit && (state_q == S_IDLE) && !flush;

   // Assemble the little-endian word starting at the byte offset of fetch_pc.
   always_comb begin
      fetch_inst = '0;
      if (fetch_hit) begin
         for (int k = 0; k < 4; k++) begin
            fetch_inst[8*k +: 8] = data_mem[pc_idx][pc_off + OFF'(k)];
         end
      end
   end

   // Next-state logic: issue a fill on a miss, wait for done, and decide
   // whether the returning line is installed or discarded after a flush.
   always_comb begin
      state_d     = state_q;
      mem_if_en_d = mem_if_en;
      mem_if_pc_d = mem_if_pc;
      drop_d      = drop_q;
      miss_idx_d  = miss_idx_q;
      miss_tag_d  = miss_tag_q;
      fill_we     = 1'b0;
      clear_all   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               clear_all = 1'b1;
            end else if (fetch_en && !lookup_hit) begin
               state_d     = S_WAIT;
               mem_if_en_d = 1'b1;
               mem_if_pc_d = {fetch_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
               miss_idx_d  = pc_idx;
               miss_tag_d  = pc_tag;
            end
         end
         S_WAIT: begin
            if (flush) begin
               clear_all = 1'b1;
               drop_d    = 1'b1;
            end
            if (mem_if_done) begin
               mem_if_en_d = 1'b0;
               fill_we     = !drop_q && !flush;
               drop_d      = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state and request registers; rdy low freezes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         mem_if_en  <= 1'b0;
         mem_if_pc  <= '0;
         drop_q     <= 1'b0;
         miss_idx_q <= '0;
         miss_tag_q <= '0;
      end else if (rdy) begin
         state_q    <= state_d;
         mem_if_en  <= mem_if_en_d;
         mem_if_pc  <= mem_if_pc_d;
         drop_q     <= drop_d;
         miss_idx_q <= miss_idx_d;
         miss_tag_q <= miss_tag_d;
      end
   end

   // Valid bits are the only part of the array cleared by reset or flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (rdy) begin
         if (clear_all) begin
            valid_q <= '0;
         end else if (fill_we) begin
            valid_q[miss_idx_q] <= 1'b1;
         end
      end
   end

   // Tag and line storage are written only when a fill is accepted.
   always_ff @(posedge clk) begin
      if (rdy && fill_we) begin
         tag_mem[miss_idx_q] <= miss_tag_q;
         for (int b = 0; b < LINE_BYTES; b++) begin
            data_mem[miss_idx_q][b] <= mem_if_data[8*b +: 8];
         end
      end
   end

endmodule
